// File: rtl/free_list_pkg.sv
// Shared core sizing for the free list, ROB and rename.
package free_list_pkg;
  localparam int unsigned NBANK         = 4;
  localparam int unsigned LANE_W        = 2;
  localparam int unsigned NREL_W        = 3;
  localparam int unsigned DEF_WIDTH_REG = 7;
  localparam int unsigned DEF_NARCH     = 32;
endpackage

// File: rtl/fl_compact.sv
// Squeezes the nonzero commit-release lanes into the low lanes, in lane order, and counts them.
module fl_compact
  import free_list_pkg::*;
#(
  parameter int unsigned W = DEF_WIDTH_REG
) (
  input  logic [NBANK*W-1:0] prd4x,
  input  logic               en,
  output logic [NBANK*W-1:0] cmp4x,
  output logic [NREL_W-1:0]  nrel
);

  always_comb begin
    cmp4x = '0;
    nrel  = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (en && (prd4x[k*W +: W] != '0)) begin
        cmp4x[nrel[LANE_W-1:0]*W +: W] = prd4x[k*W +: W];
        nrel = nrel + NREL_W'(1);
      end
    end
  end

endmodule

// File: rtl/free_list.sv
// Physical register free list: circular buffer offering four tags per cycle to rename.
// Optional double-free checking is enabled with FREE_LIST_CHK_EN.
module free_list
  import free_list_pkg::*;
#(
  parameter int unsigned WIDTH_REG = DEF_WIDTH_REG,
  parameter int unsigned NARCH     = DEF_NARCH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic [NBANK*WIDTH_REG-1:0] o_alloc_prd4x,
  output logic                       o_alloc_rdy,
  input  logic                       i_alloc_en,
  input  logic [NBANK*WIDTH_REG-1:0] i_com_prd4x,
  input  logic                       i_com_en,
  output logic [WIDTH_REG:0]         o_count,
  output logic                       o_err
);

  localparam int unsigned SIZE  = 2**WIDTH_REG;
  localparam int unsigned NFREE = SIZE - NARCH;

  logic [WIDTH_REG-1:0]       mem [SIZE];
  logic [WIDTH_REG-1:0]       head;
  logic [WIDTH_REG-1:0]       tail;
  logic [WIDTH_REG:0]         count;
  logic [WIDTH_REG:0]         count_nxt;
  logic                       alloc_acc;
  logic [NBANK*WIDTH_REG-1:0] cmp4x;
  logic [NREL_W-1:0]          nrel;

  fl_compact #(.W(WIDTH_REG)) u_compact (
    .prd4x (i_com_prd4x),
    .en    (i_com_en),
    .cmp4x (cmp4x),
    .nrel  (nrel)
  );

  // Offered tags are read straight out of the buffer at head.
  always_comb begin
    o_alloc_prd4x = '0;
    for (int k = 0; k < NBANK; k++) begin
      o_alloc_prd4x[k*WIDTH_REG +: WIDTH_REG] = mem[head + WIDTH_REG'(k)];
    end
  end

  assign o_alloc_rdy = (count >= (WIDTH_REG+1)'(NBANK));
  assign alloc_acc   = i_alloc_en & o_alloc_rdy;
  assign count_nxt   = count - (alloc_acc ? (WIDTH_REG+1)'(NBANK) : '0) + (WIDTH_REG+1)'(nrel);
  assign o_count     = count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head  <= '0;
      tail  <= WIDTH_REG'(NFREE);
      count <= (WIDTH_REG+1)'(NFREE);
    end else begin
      if (alloc_acc) head <= head + WIDTH_REG'(NBANK);
      tail  <= tail + WIDTH_REG'(nrel);
      count <= count_nxt;
    end
  end

  // Reset seeds the buffer with every non-architectural tag in ascending order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < SIZE; k++) begin
        if (k < NFREE) mem[k] <= WIDTH_REG'(NARCH + k);
      end
    end else begin
      for (int k = 0; k < NBANK; k++) begin
        if (NREL_W'(k) < nrel) mem[tail + WIDTH_REG'(k)] <= cmp4x[k*WIDTH_REG +: WIDTH_REG];
      end
    end
  end

`ifdef FREE_LIST_CHK_EN
  logic [SIZE-1:0] free_bm;
  logic [SIZE-1:0] bm_nxt;
  logic            dfree_c;

  // Flags a release of an already-free tag or the same tag twice in one commit.
  always_comb begin
    bm_nxt  = free_bm;
    dfree_c = 1'b0;
    if (i_com_en) begin
      for (int j = 0; j < NBANK; j++) begin
        if (i_com_prd4x[j*WIDTH_REG +: WIDTH_REG] != '0) begin
          if (free_bm[i_com_prd4x[j*WIDTH_REG +: WIDTH_REG]]) dfree_c = 1'b1;
          for (int i = 0; i < j; i++) begin
            if (i_com_prd4x[i*WIDTH_REG +: WIDTH_REG] == i_com_prd4x[j*WIDTH_REG +: WIDTH_REG])
              dfree_c = 1'b1;
          end
        end
      end
    end
    if (alloc_acc) begin
      for (int k = 0; k < NBANK; k++) bm_nxt[o_alloc_prd4x[k*WIDTH_REG +: WIDTH_REG]] = 1'b0;
    end
    if (i_com_en) begin
      for (int j = 0; j < NBANK; j++) begin
        if (i_com_prd4x[j*WIDTH_REG +: WIDTH_REG] != '0)
          bm_nxt[i_com_prd4x[j*WIDTH_REG +: WIDTH_REG]] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < SIZE; k++) free_bm[k] <= (k >= NARCH);
      o_err <= 1'b0;
    end else begin
      free_bm <= bm_nxt;
      o_err   <= o_err | dfree_c;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule
